mc_datapath: RTL and testbench

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath_pkg.sv | 24 ++
 rtl/regfile_n.sv | 41 ++++
 rtl/mc_datapath.sv | 192 +++++++++++++++++++
 tb/tb_mc_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_datapath_pkg.sv
// Shared types and instruction field positions for the multi-cycle datapath.
package mc_datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MEM  = 2'b10,
        WB   = 2'b11
    } state_e;

    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned IMM_W     = 16;

endpackage

// File: rtl/regfile_n.sv
// Register file: two combinational read ports, one write port, register 0 hardwired to zero.
module regfile_n #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra_a,
    input  logic [4:0]        ra_b,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Index bits above AW are dropped; a write aimed at register 0 is discarded.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa[AW-1:0] != '0)) begin
            regs_d[wa[AW-1:0]] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a = (ra_a[AW-1:0] == '0) ? '0 : regs_q[ra_a[AW-1:0]];
    assign rd_b = (ra_b[AW-1:0] == '0) ? '0 : regs_q[ra_b[AW-1:0]];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: IDLE -> EXEC -> [MEM] -> [WB], register file plus inline ALU and data memory.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       Instructions,
    input  logic              RegDst,
    input  logic              RegWr,
    input  logic              ALUsrc,
    input  logic              MemWr,
    input  logic              MemToReg,
    input  logic [1:0]        ALUcntrl,
    output logic [DATA_W-1:0] seOut,
    output logic [DATA_W-1:0] reg_Da,
    output logic              Zero,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam int MAW = $clog2(DMEM_WORDS);

    state_e            state_q, state_d;
    alu_op_e           aluop_q, aluop_d;
    logic              regdst_q, regdst_d, regwr_q, regwr_d, alusrc_q, alusrc_d;
    logic              memwr_q, memwr_d, memtoreg_q, memtoreg_d;
    logic [4:0]        rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] da_q, da_d, db_q, db_d, se_q, se_d;
    logic [DATA_W-1:0] result_q, result_d, load_q, load_d;
    logic              zero_q, zero_d, wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [DATA_W-1:0] rf_rd_a, rf_rd_b, alu_b, wr_data;
    logic [4:0]        wr_addr;
    logic              rf_we, mem_we;
    logic [MAW-1:0]    mem_idx;
    logic [DATA_W-1:0] mem_q [DMEM_WORDS];
    logic [IMM_W-1:0]  imm;
    logic              unused_op_bits;

    assign unused_op_bits = ^Instructions[31:26];
    assign imm     = Instructions[IMM_W-1:0];
    assign alu_b   = alusrc_q ? se_q : db_q;
    assign mem_idx = result_q[MAW+1:2];
    assign wr_addr = regdst_q ? rd_q : rt_q;
    assign wr_data = memtoreg_q ? load_q : result_q;
    assign rf_we   = (state_q == WB) && regwr_q;

    regfile_n #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .ra_a (Instructions[RS_LSB +: REG_IDX_W]),
        .ra_b (Instructions[RT_LSB +: REG_IDX_W]),
        .we   (rf_we),
        .wa   (wr_addr),
        .wd   (wr_data),
        .rd_a (rf_rd_a),
        .rd_b (rf_rd_b)
    );

    always_comb begin
        state_d    = state_q;
        aluop_d    = aluop_q;
        regdst_d   = regdst_q;
        regwr_d    = regwr_q;
        alusrc_d   = alusrc_q;
        memwr_d    = memwr_q;
        memtoreg_d = memtoreg_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        da_d       = da_q;
        db_d       = db_q;
        se_d       = se_q;
        result_d   = result_q;
        load_d     = load_q;
        zero_d     = zero_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: if (instr_valid) begin
                aluop_d    = alu_op_e'(ALUcntrl);
                regdst_d   = RegDst;
                regwr_d    = RegWr;
                alusrc_d   = ALUsrc;
                memwr_d    = MemWr;
                memtoreg_d = MemToReg;
                rt_d       = Instructions[RT_LSB +: REG_IDX_W];
                rd_d       = Instructions[RD_LSB +: REG_IDX_W];
                da_d       = rf_rd_a;
                db_d       = rf_rd_b;
                se_d       = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                state_d    = EXEC;
            end
            EXEC: begin
                case (aluop_q)
                    ALU_ADD: result_d = da_q + alu_b;
                    ALU_SUB: result_d = da_q - alu_b;
                    ALU_AND: result_d = da_q & alu_b;
                    default: result_d = da_q | alu_b;
                endcase
                zero_d  = (result_d == '0);
                state_d = (memwr_q || memtoreg_q) ? MEM : (regwr_q ? WB : IDLE);
            end
            MEM: begin
                mem_we = memwr_q;
                // Store-then-load of the same word forwards the stored data.
                if (memtoreg_q) begin
                    load_d = memwr_q ? db_q : mem_q[mem_idx];
                end
                state_d = regwr_q ? WB : IDLE;
            end
            WB: begin
                wb_valid_d = 1'b1;
                wb_addr_d  = wr_addr;
                wb_data_d  = wr_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            aluop_q    <= ALU_ADD;
            regdst_q   <= 1'b0;
            regwr_q    <= 1'b0;
            alusrc_q   <= 1'b0;
            memwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            rt_q       <= '0;
            rd_q       <= '0;
            da_q       <= '0;
            db_q       <= '0;
            se_q       <= '0;
            result_q   <= '0;
            load_q     <= '0;
            zero_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            aluop_q    <= aluop_d;
            regdst_q   <= regdst_d;
            regwr_q    <= regwr_d;
            alusrc_q   <= alusrc_d;
            memwr_q    <= memwr_d;
            memtoreg_q <= memtoreg_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            da_q       <= da_d;
            db_q       <= db_d;
            se_q       <= se_d;
            result_q   <= result_d;
            load_q     <= load_d;
            zero_q     <= zero_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Memory contents survive reset; reset forces IDLE so no write can occur while it is held.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= db_q;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign seOut       = se_q;
    assign reg_Da      = da_q;
    assign Zero        = zero_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed-vector bench for mc_datapath with hand-computed expected write-backs.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] Instructions = '0;
    logic        RegDst = 1'b0, RegWr = 1'b0, ALUsrc = 1'b0, MemWr = 1'b0, MemToReg = 1'b0;
    logic [1:0]  ALUcntrl = 2'b00;
    logic [31:0] seOut, reg_Da, wb_data;
    logic        Zero, wb_valid;
    logic [4:0]  wb_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] se_obs, da_obs;

    // Control bundles: {RegDst, RegWr, ALUsrc, MemWr, MemToReg}
    localparam logic [4:0] C_ADDI = 5'b01100;
    localparam logic [4:0] C_R    = 5'b11000;
    localparam logic [4:0] C_SW   = 5'b00110;
    localparam logic [4:0] C_LW   = 5'b01101;
    localparam logic [4:0] C_SWLW = 5'b01111;

    mc_datapath #(
        .DATA_W     (32),
        .NREGS      (32),
        .DMEM_WORDS (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .Instructions (Instructions),
        .RegDst       (RegDst),
        .RegWr        (RegWr),
        .ALUsrc       (ALUsrc),
        .MemWr        (MemWr),
        .MemToReg     (MemToReg),
        .ALUcntrl     (ALUcntrl),
        .seOut        (seOut),
        .reg_Da       (reg_Da),
        .Zero         (Zero),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] itype(input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = 5'(rs);
        t = 5'(rt);
        return {6'b0, s, t, imm};
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        logic [4:0] d;
        d = 5'(rd);
        return itype(rs, rt, {d, 11'b0});
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [4:0] c, input logic [1:0] op);
        Instructions = ins;
        {RegDst, RegWr, ALUsrc, MemWr, MemToReg} = c;
        ALUcntrl = op;
    endtask

    // exp_lat: edges from transfer to wb_valid (0 = no write-back); exp_rdy: edges until IDLE again.
    task automatic run(input string tag, input logic [31:0] ins, input logic [4:0] c,
                       input logic [1:0] op, input int exp_lat, input int exp_rdy,
                       input logic [4:0] exp_addr, input logic [31:0] exp_data);
        int seen, rdy;
        logic [4:0]  a;
        logic [31:0] d;
        seen = 0; rdy = 0; a = '0; d = '0;
        @(negedge clk);
        check({tag, "/ready_in"}, instr_ready, 1);
        drive(ins, c, op);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        se_obs = seOut;
        da_obs = reg_Da;
        drive(~ins, ~c, ~op);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (wb_valid && seen == 0) begin
                seen = k; a = wb_addr; d = wb_data;
            end
            if (instr_ready && rdy == 0) rdy = k;
        end
        check({tag, "/wb_lat"}, seen, exp_lat);
        check({tag, "/rdy_lat"}, rdy, exp_rdy);
        if (exp_lat != 0) begin
            check({tag, "/wb_addr"}, a, exp_addr);
            check({tag, "/wb_data"}, d, exp_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, instr_ready, 1);
        check({tag, "/zero"}, Zero, 0);
        check({tag, "/wb_valid"}, wb_valid, 0);
        check({tag, "/wb_addr"}, wb_addr, 0);
        check({tag, "/wb_data"}, wb_data, 0);
        check({tag, "/seOut"}, seOut, 0);
        check({tag, "/reg_Da"}, reg_Da, 0);
    endtask

    initial begin
        int wb_cnt;
        logic [31:0] wbd [3];

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        run("addi1", itype(0, 1, 16'd2015), C_ADDI, 2'b00, 2, 2, 5'd1, 32'd2015);
        check("addi1/seOut", se_obs, 32'd2015);
        check("addi1/reg_Da", da_obs, 0);
        run("addi2", itype(0, 2, 16'd404), C_ADDI, 2'b00, 2, 2, 5'd2, 32'd404);
        run("add", rtype(1, 2, 1), C_R, 2'b00, 2, 2, 5'd1, 32'd2419);
        check("add/reg_Da", da_obs, 32'd2015);
        check("add/zero", Zero, 0);
        run("sub", rtype(1, 1, 3), C_R, 2'b01, 2, 2, 5'd3, 32'd0);
        check("sub/zero", Zero, 1);
        run("and", rtype(1, 2, 7), C_R, 2'b10, 2, 2, 5'd7, 32'd272);
        run("or", rtype(1, 2, 8), C_R, 2'b11, 2, 2, 5'd8, 32'd2551);
        run("addi_neg", itype(0, 9, 16'hFFFF), C_ADDI, 2'b00, 2, 2, 5'd9, 32'hFFFF_FFFF);
        check("addi_neg/seOut", se_obs, 32'hFFFF_FFFF);

        run("sw0", itype(0, 2, 16'd0), C_SW, 2'b00, 0, 2, 5'd0, 32'd0);
        run("lw0", itype(0, 3, 16'd0), C_LW, 2'b00, 3, 3, 5'd3, 32'd404);
        run("lw_alias", itype(0, 4, 16'd256), C_LW, 2'b00, 3, 3, 5'd4, 32'd404);
        check("lw_alias/zero", Zero, 0);

        run("addi_r0", itype(0, 0, 16'd7), C_ADDI, 2'b00, 2, 2, 5'd0, 32'd7);
        run("read_r0", rtype(0, 2, 6), C_R, 2'b00, 2, 2, 5'd6, 32'd404);
        check("read_r0/reg_Da", da_obs, 0);

        run("sw8", itype(0, 2, 16'd8), C_SW, 2'b00, 0, 2, 5'd0, 32'd0);
        run("swlw8", itype(0, 1, 16'd8), C_SWLW, 2'b00, 3, 3, 5'd1, 32'd2419);
        run("lw8", itype(0, 7, 16'd8), C_LW, 2'b00, 3, 3, 5'd7, 32'd2419);

        // Valid held high: one transfer per IDLE visit, garbage controls while busy.
        wb_cnt = 0;
        wbd = '{default: '0};
        instr_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (instr_ready) drive(itype(5, 5, 16'd1), C_ADDI, 2'b00);
            else drive(itype(1, 6, 16'h7FFF), C_SWLW, 2'b01);
            @(posedge clk);
            #1;
            if (wb_valid) begin
                if (wb_cnt < 3) wbd[wb_cnt] = wb_data;
                wb_cnt++;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("stream/count", wb_cnt, 3);
        check("stream/wb0", wbd[0], 32'd1);
        check("stream/wb1", wbd[1], 32'd2);
        check("stream/wb2", wbd[2], 32'd3);

        // Reset during MEM of a store must leave the memory word untouched.
        run("sw12", itype(0, 2, 16'd12), C_SW, 2'b00, 0, 2, 5'd0, 32'd0);
        @(negedge clk);
        drive(itype(0, 1, 16'd12), C_SW, 2'b00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mem");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run("lw12", itype(0, 3, 16'd12), C_LW, 2'b00, 3, 3, 5'd3, 32'd404);
        run("r1_cleared", rtype(1, 0, 10), C_R, 2'b00, 2, 2, 5'd10, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
